// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with an optional parity bit.
// Turns the asynchronous serial line into 8-bit bytes plus one-cycle strobes
// for good data, framing errors and parity errors. There is no backpressure.
//
// Build option: define UART_RX_PARITY_EN to insert a parity bit between the
// last data bit and the stop bit. The PARITY_ODD parameter selects its sense.
// Without the macro the frame is 10 bits and parity_err is tied low.

module uart_rx #(
    parameter int CLKS_PER_BIT = 16,  // clock cycles per bit; even and >= 4
    parameter int PARITY_ODD   = 0    // 0 = even parity, 1 = odd parity
) (
    input  logic       clk,
    input  logic       reset,       // asynchronous, active low
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Start bit is checked at its middle; every later bit one full period on.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    // Reject configurations the sampling scheme cannot support.
    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks
        $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity
        $error("uart_rx: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

    state_e           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_out_q;
    logic             data_valid_q;
    logic             frame_err_q;
    logic             busy_q;

`ifdef UART_RX_PARITY_EN
    logic             par_err_q;     // parity mismatch seen in this frame
    logic             parity_err_q;
    logic             par_expected;

    // Parity bit the transmitter should have sent for the byte just shifted in.
    always_comb begin
        par_expected = (PARITY_ODD != 0) ? ~^shift_q : ^shift_q;
    end
`endif

    // Two-flop synchroniser; the line idles high so both flops reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make rx_s_q take the old rx_meta_q,
            // giving two real flop stages; blocking here would collapse them.
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM with its counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            // NOTE: the shift register is reset too, so a frame cut short by
            // reset can never leak stale bits into data_out.
            shift_q      <= '0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low every cycle and are only set on the
            // transition out of STOP, so each lasts exactly one clock.
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                    par_err_q <= 1'b0;
`endif
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            // Line went back high mid start bit: a glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        par_err_q <= (rx_s_q != par_expected);
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_err_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_out_q   <= shift_q;
                                data_valid_q <= 1'b1;
                            end
`else
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
`endif
                        end else begin
                            // Stop bit low: framing error, wait out the break.
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_err_q;
`endif
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                BREAK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver stage that sits directly upstream of the home-security UART consumer.
- Converts the asynchronous serial line `rx` into 8-bit bytes plus a single-cycle `data_valid` strobe that feeds the downstream stage's 8-bit data input.
- Frame format is 8N1, LSB first, with an optional parity bit.
- No backpressure: the downstream stage must accept each byte in the cycle `data_valid` is high.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; must be even and >= 4.
- PARITY_ODD, 0, parity sense when PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset asserted when 0.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  8  last correctly received byte.
- data_valid  output  1  one-cycle strobe; data_out is new and valid.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- parity_err  output  1  one-cycle strobe; parity mismatch (constant 0 without PARITY_EN).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, both sync flops=1, bit counter=0, cycle counter=0, shift register=0.
  - data_out=8'h00; data_valid, frame_err, parity_err, busy all 0.
- Synchroniser: rx passes through two flops; rx_s is the second flop. Only rx_s is used by the FSM.
- Cycle counter is clog2(CLKS_PER_BIT) bits wide. It clears on every state change and on every bit sample; it never wraps mid-bit.
- States: IDLE, START, DATA, PARITY (PARITY_EN only), STOP, BREAK.
- IDLE: when rx_s==0 -> START.
- START: when cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - rx_s==0 -> DATA.
  - rx_s==1 (glitch / false start) -> IDLE; no strobes.
- DATA: when cnt==CLKS_PER_BIT-1, shift in rx_s, LSB first (shift right, new bit into bit 7).
  - After the 8th sample -> PARITY if enabled, else STOP.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1, no parity error: data_out <= shift register, data_valid=1 for exactly one cycle, -> IDLE.
  - rx_s==0: frame_err=1 for one cycle, data_out unchanged, -> BREAK.
- BREAK: stay until rx_s==1, then -> IDLE. This prevents re-triggering during a line break.
- Strobe timing: all strobes are registered and coincide with the transition out of STOP. No strobe is ever asserted in two consecutive cycles.
- Back-to-back frames: a start bit arriving right after the stop sample is accepted. IDLE sees rx_s==0 on the next cycle, so there is no lost frame at exactly 1 stop bit.
- Latency: data_valid rises 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clock edges after the first edge that samples rx low.
  - CLKS_PER_BIT=16: 155 edges.
  - CLKS_PER_BIT=16 with PARITY_EN: 171 edges.
- Reset mid-frame: immediate return to the reset state. A partial byte is discarded and produces no strobe.
- Between strobes, data_out holds its value indefinitely.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; samples one parity bit at cnt==CLKS_PER_BIT-1.
  - Expected value is ^data for even parity, ~^data for odd parity.
  - Mismatch: parity_err=1 in the same cycle STOP would have strobed, data_valid stays 0, data_out unchanged.
  - If the stop bit is also 0, both frame_err and parity_err strobe, and the FSM goes -> BREAK.
- Not defined:
  - No PARITY state; parity_err is tied to 0.
  - Frame is 10 bits.

Test Plan:
- Reset held low while rx toggles randomly -> all outputs stay 0 and data_out=8'h00. Release reset -> busy stays 0 while rx=1.
- CLKS_PER_BIT=16, send 8'hA5 as 8N1 -> data_valid high for 1 cycle exactly 155 edges after the start edge; data_out=8'hA5; frame_err=0.
- Send 8'h3C then 8'hFF back-to-back with one stop bit -> two data_valid pulses 160 edges apart; data_out=8'h3C then 8'hFF.
- Low glitch of 4 cycles on idle rx -> FSM returns to IDLE; no strobes; busy high for at most 10 cycles.
- Send 8'h55 with stop bit forced 0, then hold rx low 40 cycles -> frame_err one-cycle pulse; data_out retains previous value; busy stays high until rx returns high; next valid frame received correctly.
- UART_RX_PARITY_EN, PARITY_ODD=0, send 8'h07 with parity bit 0 (wrong) -> parity_err pulse at edge 171; no data_valid. Resend with parity 1 -> data_out=8'h07, data_valid pulse.
